// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - write/read pointer control for a 2^ADDR_WIDTH-entry synchronous FIFO
//
// Purpose:
//   Owns the write and read pointers of the FIFO. Each pointer is ADDR_WIDTH+1
//   bits: the low ADDR_WIDTH bits address the dual-port RAM, the top bit is the
//   wrap bit used by the external full/empty status logic. Full/Empty come back
//   from that logic and gate pointer advances; they are trusted as given.
//   Also produces the handshake strobes, fill level, threshold flags and sticky
//   error flags. Every output is registered.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   WR_EN/RD_EN   write / read requests
//   FLUSH         synchronous clear of all FIFO state, highest priority
//   Full/Empty    status flags derived combinationally from WR_PTR/RD_PTR
//   WR_PTR/RD_PTR pointers {wrap, address}
//   WR_ACK        pulse the cycle after an accepted write
//   RD_VALID      pulse the cycle after an accepted read (lines up with RAM data)
//   Count         fill level 0..2^ADDR_WIDTH
//   Almost_Full   Count >= AF_LEVEL
//   Almost_Empty  Count <= AE_LEVEL
//   Overflow      sticky, write request while Full
//   Underflow     sticky, read request while Empty

module fifo_ptr_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int AF_LEVEL   = 240,
   parameter int AE_LEVEL   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WR_EN,
   input  logic                  RD_EN,
   input  logic                  FLUSH,
   input  logic                  Full,
   input  logic                  Empty,
   output logic [ADDR_WIDTH:0]   WR_PTR,
   output logic [ADDR_WIDTH:0]   RD_PTR,
   output logic                  WR_ACK,
   output logic                  RD_VALID,
   output logic [ADDR_WIDTH:0]   Count,
   output logic                  Almost_Full,
   output logic                  Almost_Empty,
   output logic                  Overflow,
   output logic                  Underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] LP_AF  = PW'(AF_LEVEL);
   localparam logic [PW-1:0] LP_AE  = PW'(AE_LEVEL);
   localparam logic [PW-1:0] LP_ONE = PW'(1);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_count;
   logic          r_wr_ack;
   logic          r_rd_valid;
   logic          r_almost_full;
   logic          r_almost_empty;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_wr_acc;
   logic          w_rd_acc;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [PW-1:0] w_rd_ptr_nxt;
   logic [PW-1:0] w_count_nxt;
   logic          w_overflow_nxt;
   logic          w_underflow_nxt;

   // While Full a simultaneous read still goes through (frees a slot) and while
   // Empty a simultaneous write still goes through; only the blocked side is
   // rejected. Reads never fall through on an empty FIFO.
   assign w_wr_acc = WR_EN & ~Full  & ~FLUSH;
   assign w_rd_acc = RD_EN & ~Empty & ~FLUSH;

   always_comb begin
      w_wr_ptr_nxt    = r_wr_ptr;
      w_rd_ptr_nxt    = r_rd_ptr;
      w_overflow_nxt  = r_overflow;
      w_underflow_nxt = r_underflow;
      if (FLUSH) begin
         w_wr_ptr_nxt    = '0;
         w_rd_ptr_nxt    = '0;
         w_overflow_nxt  = 1'b0;
         w_underflow_nxt = 1'b0;
      end else begin
         // Natural PW-bit rollover toggles the wrap bit on address 255->0.
         if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + LP_ONE;
         if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + LP_ONE;
         if (WR_EN & Full)  w_overflow_nxt  = 1'b1;
         if (RD_EN & Empty) w_underflow_nxt = 1'b1;
      end
   end

   // Derived from the next pointers so Count can never disagree with them;
   // modulo-2^PW subtraction gives 0..2^ADDR_WIDTH when Full/Empty are honest.
   assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_wr_ack       <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_wr_ptr       <= w_wr_ptr_nxt;
         r_rd_ptr       <= w_rd_ptr_nxt;
         r_count        <= w_count_nxt;
         r_wr_ack       <= w_wr_acc;
         r_rd_valid     <= w_rd_acc;
         r_almost_full  <= (w_count_nxt >= LP_AF);
         r_almost_empty <= (w_count_nxt <= LP_AE);
         r_overflow     <= w_overflow_nxt;
         r_underflow    <= w_underflow_nxt;
      end
   end

   assign WR_PTR       = r_wr_ptr;
   assign RD_PTR       = r_rd_ptr;
   assign Count        = r_count;
   assign WR_ACK       = r_wr_ack;
   assign RD_VALID     = r_rd_valid;
   assign Almost_Full  = r_almost_full;
   assign Almost_Empty = r_almost_empty;
   assign Overflow     = r_overflow;
   assign Underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - scoreboard testbench for fifo_ptr_ctrl
module tb_fifo_ptr_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       WR_EN = 1'b0;
   logic       RD_EN = 1'b0;
   logic       FLUSH = 1'b0;
   logic       Full;
   logic       Empty;
   logic [8:0] WR_PTR;
   logic [8:0] RD_PTR;
   logic       WR_ACK;
   logic       RD_VALID;
   logic [8:0] Count;
   logic       Almost_Full;
   logic       Almost_Empty;
   logic       Overflow;
   logic       Underflow;

   int total = 0;
   int bad   = 0;
   int rv_pulses = 0;

   logic [8:0] wq[$];
   logic [8:0] rq[$];

   logic [8:0] m_wr = '0;
   logic [8:0] m_rd = '0;
   logic [8:0] m_cnt;
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;

   always #5 clk = ~clk;

   // External status logic, closed around the DUT pointers.
   assign Full  = (WR_PTR[8] != RD_PTR[8]) && (WR_PTR[7:0] == RD_PTR[7:0]);
   assign Empty = (WR_PTR == RD_PTR);

   fifo_ptr_ctrl dut (
      .clk(clk), .rst(rst), .WR_EN(WR_EN), .RD_EN(RD_EN), .FLUSH(FLUSH),
      .Full(Full), .Empty(Empty), .WR_PTR(WR_PTR), .RD_PTR(RD_PTR),
      .WR_ACK(WR_ACK), .RD_VALID(RD_VALID), .Count(Count),
      .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty),
      .Overflow(Overflow), .Underflow(Underflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation and
   // every expectation must be met on the very next sample.
   always @(negedge clk) begin
      if (WR_ACK) begin
         if (wq.size() == 0) chk("wr_ack_unexpected", 1, 0);
         else chk("wr_ack_ptr", int'(WR_PTR), int'(wq.pop_front()));
      end else if (wq.size() != 0) begin
         chk("wr_ack_missing", 0, 1);
         wq.delete();
      end
      if (RD_VALID) begin
         rv_pulses++;
         if (rq.size() == 0) chk("rd_valid_unexpected", 1, 0);
         else chk("rd_valid_ptr", int'(RD_PTR), int'(rq.pop_front()));
      end else if (rq.size() != 0) begin
         chk("rd_valid_missing", 0, 1);
         rq.delete();
      end
   end

   task automatic step(input bit we, input bit re, input bit fl);
      bit mf, me, wa, ra;
      WR_EN = we; RD_EN = re; FLUSH = fl;
      mf = ((m_wr ^ m_rd) == 9'h100);
      me = (m_wr == m_rd);
      wa = we && !mf && !fl;
      ra = re && !me && !fl;
      @(posedge clk);
      if (fl) begin
         m_wr = '0; m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         if (we && mf) m_ovf = 1'b1;
         if (re && me) m_udf = 1'b1;
         if (wa) m_wr = m_wr + 9'd1;
         if (ra) m_rd = m_rd + 9'd1;
      end
      if (wa) wq.push_back(m_wr);
      if (ra) rq.push_back(m_rd);
      #1;
      WR_EN = 1'b0; RD_EN = 1'b0; FLUSH = 1'b0;
      m_cnt = m_wr - m_rd;
      chk("count", int'(Count), int'(m_cnt));
      chk("overflow", int'(Overflow), int'(m_ovf));
      chk("underflow", int'(Underflow), int'(m_udf));
      chk("almost_full", int'(Almost_Full), int'(m_cnt >= 9'd240));
      chk("almost_empty", int'(Almost_Empty), int'(m_cnt <= 9'd16));
   endtask

   task automatic check_reset_values();
      chk("rst_wr_ptr", int'(WR_PTR), 0);
      chk("rst_rd_ptr", int'(RD_PTR), 0);
      chk("rst_count", int'(Count), 0);
      chk("rst_wr_ack", int'(WR_ACK), 0);
      chk("rst_rd_valid", int'(RD_VALID), 0);
      chk("rst_overflow", int'(Overflow), 0);
      chk("rst_underflow", int'(Underflow), 0);
      chk("rst_almost_full", int'(Almost_Full), 0);
      chk("rst_almost_empty", int'(Almost_Empty), 1);
   endtask

   // Called at posedge+1 with a burst in flight; asserts rst between edges.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      wq.delete(); rq.delete();
      #1;
      check_reset_values();
      m_wr = '0; m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      WR_EN = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rv_base;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_values();

      // Async reset with no clock edge, after some activity.
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      chk("pre_reset_wr_ptr", int'(WR_PTR), 3);
      async_reset();

      // Fill from empty.
      for (int i = 0; i < 256; i++) step(1, 0, 0);
      chk("fill_wr_ptr", int'(WR_PTR), 9'h100);
      chk("fill_rd_ptr", int'(RD_PTR), 0);
      chk("fill_count", int'(Count), 256);
      chk("fill_full", int'(Full), 1);
      step(1, 0, 0);
      chk("ovf_wr_ptr_hold", int'(WR_PTR), 9'h100);
      chk("ovf_flag", int'(Overflow), 1);

      // Drain and wrap.
      rv_base = rv_pulses;
      for (int i = 0; i < 256; i++) step(0, 1, 0);
      chk("drain_rd_ptr", int'(RD_PTR), 9'h100);
      chk("drain_count", int'(Count), 0);
      chk("drain_empty", int'(Empty), 1);
      step(0, 1, 0);
      chk("drain_rd_valid_pulses", rv_pulses - rv_base, 256);
      chk("udf_flag", int'(Underflow), 1);
      chk("udf_rd_ptr_hold", int'(RD_PTR), 9'h100);
      for (int i = 0; i < 256; i++) step(1, 0, 0);
      chk("wrap_wr_ptr", int'(WR_PTR), 9'h000);
      chk("wrap_full", int'(Full), 1);

      // Clear, then both requests while Empty.
      step(0, 0, 1);
      chk("flush1_wr_ptr", int'(WR_PTR), 0);
      step(1, 1, 0);
      chk("empty_both_wr_ptr", int'(WR_PTR), 1);
      chk("empty_both_rd_ptr", int'(RD_PTR), 0);
      chk("empty_both_udf", int'(Underflow), 1);
      step(0, 0, 1);

      // Simultaneous traffic at Count = 100.
      for (int i = 0; i < 100; i++) step(1, 0, 0);
      for (int i = 0; i < 50; i++) step(1, 1, 0);
      chk("simul_wr_ptr", int'(WR_PTR), 150);
      chk("simul_rd_ptr", int'(RD_PTR), 50);
      chk("simul_count", int'(Count), 100);

      // Both requests while Full.
      for (int i = 0; i < 156; i++) step(1, 0, 0);
      chk("full2_count", int'(Count), 256);
      step(1, 1, 0);
      chk("full_both_wr_ptr", int'(WR_PTR), 9'h132);
      chk("full_both_rd_ptr", int'(RD_PTR), 51);
      chk("full_both_ovf", int'(Overflow), 1);
      chk("full_both_count", int'(Count), 255);

      // Flush at Count = 37 with Overflow set, alongside both requests.
      for (int i = 0; i < 218; i++) step(0, 1, 0);
      chk("pre_flush_count", int'(Count), 37);
      step(1, 1, 1);
      chk("flush_wr_ptr", int'(WR_PTR), 0);
      chk("flush_rd_ptr", int'(RD_PTR), 0);
      chk("flush_count", int'(Count), 0);
      chk("flush_ovf", int'(Overflow), 0);
      chk("flush_wr_ack", int'(WR_ACK), 0);
      chk("flush_rd_valid", int'(RD_VALID), 0);
      chk("flush_ae", int'(Almost_Empty), 1);
      chk("flush_af", int'(Almost_Full), 0);

      // Async reset during a write burst at Count = 80.
      for (int i = 0; i < 80; i++) step(1, 0, 0);
      chk("burst_count", int'(Count), 80);
      WR_EN = 1'b1;
      async_reset();
      step(1, 0, 0);
      chk("post_rst_wr_ptr", int'(WR_PTR), 1);
      step(0, 0, 0);
      chk("post_rst_ack_seen", wq.size(), 0);

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
